// File: rtl/rf_wb_arbiter.sv
// Round-robin arbiter sharing the register bank write port between NUM_REQ
// writeback sources, with a one-entry output stage that the pipeline can hold.
module rf_wb_arbiter #(
    parameter int NUM_REQ = 2,
    parameter int LANES   = 16,
    parameter int ADDR_W  = 5,
    parameter int DATA_W  = 32
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic [NUM_REQ-1:0]               req_valid,
    output logic [NUM_REQ-1:0]               req_ready,
    input  logic [NUM_REQ*ADDR_W-1:0]        req_waddr,
    input  logic [NUM_REQ*LANES-1:0]         req_mask,
    input  logic [NUM_REQ*LANES*DATA_W-1:0]  req_wdata,
    input  logic                             wb_hold,
    output logic [LANES-1:0]                 write_en,
    output logic [ADDR_W-1:0]                waddr,
    output logic [LANES*DATA_W-1:0]          wdata,
    output logic [1:0]                       grant_id,
    output logic [15:0]                      stall_cnt
);

    // Handshake: a write transfers on a posedge where req_valid[i] && req_ready[i].
    // req_ready is a combinational function of req_valid, so a requester must raise
    // valid without waiting for ready, and keep valid/payload stable until accepted.

    logic                      r_out_v;
    logic [LANES-1:0]          r_mask;
    logic [ADDR_W-1:0]         r_waddr;
    logic [LANES*DATA_W-1:0]   r_wdata;
    logic [1:0]                r_grant;
    logic [1:0]                r_rr_ptr;
    logic [15:0]               r_stall_cnt;

    logic                      w_drain;
    logic                      w_load_ok;
    logic                      w_found;
    logic [1:0]                w_win;
    logic                      w_accept;
    logic [1:0]                w_next_ptr;
    logic                      w_stall_inc;
    logic [ADDR_W-1:0]         w_sel_addr;
    logic [LANES-1:0]          w_sel_mask;
    logic [LANES*DATA_W-1:0]   w_sel_data;

    assign w_drain   = r_out_v && !wb_hold;
    assign w_load_ok = !r_out_v || w_drain;

    // Two passes give the wrapped scan: first requesters at/after the pointer,
    // then the ones below it.
    always_comb begin
        w_found = 1'b0;
        w_win   = 2'd0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!w_found && req_valid[i] && (2'(i) >= r_rr_ptr)) begin
                w_found = 1'b1;
                w_win   = 2'(i);
            end
        end
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!w_found && req_valid[i]) begin
                w_found = 1'b1;
                w_win   = 2'(i);
            end
        end
    end

    assign w_accept   = w_found && w_load_ok;
    assign w_next_ptr = (w_win == 2'(NUM_REQ - 1)) ? 2'd0 : (w_win + 2'd1);

    always_comb begin
        w_sel_addr = '0;
        w_sel_mask = '0;
        w_sel_data = '0;
        req_ready  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_win == 2'(i)) begin
                w_sel_addr = req_waddr[i*ADDR_W +: ADDR_W];
                w_sel_mask = req_mask[i*LANES +: LANES];
                w_sel_data = req_wdata[i*LANES*DATA_W +: LANES*DATA_W];
            end
            req_ready[i] = w_accept && (w_win == 2'(i));
        end
    end

    assign w_stall_inc = (|req_valid) && !(|(req_valid & req_ready));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_v  <= 1'b0;
            r_mask   <= '0;
            r_waddr  <= '0;
            r_wdata  <= '0;
            r_grant  <= 2'd0;
            r_rr_ptr <= 2'd0;
        end else if (w_accept) begin
            r_out_v  <= 1'b1;
            r_mask   <= w_sel_mask;
            r_waddr  <= w_sel_addr;
            r_wdata  <= w_sel_data;
            r_grant  <= w_win;
            r_rr_ptr <= w_next_ptr;
        end else if (w_drain) begin
            r_out_v  <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stall_cnt <= 16'd0;
        end else if (w_stall_inc && (r_stall_cnt != 16'hFFFF)) begin
            r_stall_cnt <= r_stall_cnt + 16'd1;
        end
    end

    // A held entry stays in the stage but must not reach the bank.
    assign write_en  = w_drain ? r_mask : '0;
    assign waddr     = r_waddr;
    assign wdata     = r_wdata;
    assign grant_id  = r_grant;
    assign stall_cnt = r_stall_cnt;

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Bench for rf_wb_arbiter: directed scenarios with literal expectations plus a
// randomized run checked every cycle against a queue-based reference model.
module tb_rf_wb_arbiter;
    localparam int N  = 2;
    localparam int L  = 16;
    localparam int AW = 5;
    localparam int DW = 32;

    typedef struct packed {
        logic [1:0]      src;
        logic [AW-1:0]   addr;
        logic [L-1:0]    mask;
        logic [L*DW-1:0] data;
    } ent_t;

    logic                 clk;
    logic                 rst_n;
    logic [N-1:0]         req_valid;
    logic [N-1:0]         req_ready;
    logic [N*AW-1:0]      req_waddr;
    logic [N*L-1:0]       req_mask;
    logic [N*L*DW-1:0]    req_wdata;
    logic                 wb_hold;
    logic [L-1:0]         write_en;
    logic [AW-1:0]        waddr;
    logic [L*DW-1:0]      wdata;
    logic [1:0]           grant_id;
    logic [15:0]          stall_cnt;

    rf_wb_arbiter #(.NUM_REQ(N), .LANES(L), .ADDR_W(AW), .DATA_W(DW)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_waddr(req_waddr), .req_mask(req_mask), .req_wdata(req_wdata),
        .wb_hold(wb_hold),
        .write_en(write_en), .waddr(waddr), .wdata(wdata),
        .grant_id(grant_id), .stall_cnt(stall_cnt)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog time limit reached");
        $fatal(1);
    end

    // ---------------- counters / check ----------------
    int n_checks = 0;
    int n_errors = 0;

    function automatic void chk(input string name, input logic [L*DW-1:0] act,
                                input logic [L*DW-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endfunction

    function automatic logic [L*DW-1:0] ramp(input logic [31:0] base);
        logic [L*DW-1:0] r;
        for (int j = 0; j < L; j++) r[j*DW +: DW] = base + 32'(j);
        return r;
    endfunction

    function automatic logic [31:0] init_val(input int r, input int j);
        return 32'hB000_0000 | 32'(r << 8) | 32'(j);
    endfunction

    // ---------------- reference model + scoreboard ----------------
    ent_t            exp_q[$];
    ent_t            m_last;
    int              m_ptr;
    int              m_stall;
    logic            p_acc, p_drain, p_stall;
    int              p_win;
    ent_t            p_ent;
    logic [L-1:0]    s_we;
    logic [AW-1:0]   s_waddr;
    logic [L*DW-1:0] s_wdata;
    logic [N-1:0]    s_ready;
    logic [31:0]     dut_bank[32][L];
    logic [31:0]     ref_bank[32][L];

    logic            c_any, c_load_ok;
    int              c_win;
    logic [N-1:0]    c_ready;
    logic [L-1:0]    c_we;

    // Compare process: inputs are stable at the falling edge.
    always @(negedge clk) begin
        if (!rst_n) begin
            chk("write_en_in_reset", L*DW'(write_en), '0);
            p_acc = 1'b0; p_drain = 1'b0; p_stall = 1'b0;
            s_we = '0; s_ready = '0;
        end else begin
            c_any     = |req_valid;
            c_load_ok = (exp_q.size() == 0) || !wb_hold;
            c_win     = -1;
            for (int k = 0; k < N; k++)
                if (c_win < 0 && req_valid[(m_ptr + k) % N]) c_win = (m_ptr + k) % N;
            c_ready = '0;
            if (c_any && c_load_ok) c_ready[c_win] = 1'b1;
            c_we = (exp_q.size() != 0 && !wb_hold) ? exp_q[0].mask : '0;

            chk("req_ready", L*DW'(req_ready), L*DW'(c_ready));
            chk("write_en", L*DW'(write_en), L*DW'(c_we));
            chk("waddr", L*DW'(waddr), L*DW'(m_last.addr));
            chk("wdata", wdata, m_last.data);
            chk("grant_id", L*DW'(grant_id), L*DW'(m_last.src));
            chk("stall_cnt", L*DW'(stall_cnt), L*DW'(m_stall));

            p_acc   = c_any && c_load_ok;
            p_win   = c_win;
            p_drain = (exp_q.size() != 0) && !wb_hold;
            p_stall = c_any && !c_load_ok;
            if (p_acc) begin
                p_ent.src  = 2'(c_win);
                p_ent.addr = req_waddr[c_win*AW +: AW];
                p_ent.mask = req_mask[c_win*L +: L];
                p_ent.data = req_wdata[c_win*L*DW +: L*DW];
            end
            s_we    = write_en;
            s_waddr = waddr;
            s_wdata = wdata;
            s_ready = req_ready;
        end
    end

    // Model state advance and both banks' commits at the active edge.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            exp_q.delete();
            m_last  = '0;
            m_ptr   = 0;
            m_stall = 0;
        end else begin
            for (int j = 0; j < L; j++)
                if (s_we[j]) dut_bank[s_waddr][j] = s_wdata[j*DW +: DW];
            if (p_drain) begin
                for (int j = 0; j < L; j++)
                    if (exp_q[0].mask[j]) ref_bank[exp_q[0].addr][j] = exp_q[0].data[j*DW +: DW];
                void'(exp_q.pop_front());
            end
            if (p_acc) begin
                exp_q.push_back(p_ent);
                m_last = p_ent;
                m_ptr  = (p_win + 1) % N;
            end
            if (p_stall && m_stall < 65535) m_stall++;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic at_neg();
        @(negedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic v, input logic [AW-1:0] a,
                           input logic [L-1:0] m, input logic [L*DW-1:0] d);
        req_valid[i]            = v;
        req_waddr[i*AW +: AW]   = a;
        req_mask[i*L +: L]      = m;
        req_wdata[i*L*DW +: L*DW] = d;
    endtask

    task automatic do_reset();
        rst_n     = 1'b0;
        req_valid = '0;
        wb_hold   = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    task automatic cmp_reg(input string name, input int r);
        logic [L*DW-1:0] a, e;
        for (int j = 0; j < L; j++) begin
            a[j*DW +: DW] = dut_bank[r][j];
            e[j*DW +: DW] = ref_bank[r][j];
        end
        chk(name, a, e);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        for (int r = 0; r < 32; r++)
            for (int j = 0; j < L; j++) begin
                dut_bank[r][j] = init_val(r, j);
                ref_bank[r][j] = init_val(r, j);
            end
        rst_n = 1'b0; req_valid = '0; req_waddr = '0; req_mask = '0; req_wdata = '0; wb_hold = 1'b0;
        do_reset();

        // Reset state
        at_neg();
        chk("rst_write_en", L*DW'(write_en), '0);
        chk("rst_stall_cnt", L*DW'(stall_cnt), '0);
        chk("rst_grant_id", L*DW'(grant_id), '0);
        chk("rst_waddr", L*DW'(waddr), '0);
        tick();

        // Single write from requester 1
        set_req(1, 1'b1, 5'h1F, 16'h00F0, ramp(32'h0));
        at_neg();
        chk("single_ready", L*DW'(req_ready), L*DW'(2'b10));
        tick();
        req_valid = '0;
        at_neg();
        chk("single_write_en", L*DW'(write_en), L*DW'(16'h00F0));
        chk("single_waddr", L*DW'(waddr), L*DW'(5'h1F));
        chk("single_grant", L*DW'(grant_id), L*DW'(2'd1));
        tick();
        chk("single_bank_l4", L*DW'(dut_bank[31][4]), L*DW'(32'd4));
        chk("single_bank_l7", L*DW'(dut_bank[31][7]), L*DW'(32'd7));
        chk("single_bank_l0", L*DW'(dut_bank[31][0]), L*DW'(init_val(31, 0)));
        chk("single_bank_l8", L*DW'(dut_bank[31][8]), L*DW'(init_val(31, 8)));
        cmp_reg("single_bank_ref", 31);

        // Round-robin fairness
        do_reset();
        set_req(0, 1'b1, 5'h10, 16'hFFFF, ramp(32'h1000_0000));
        set_req(1, 1'b1, 5'h11, 16'hFFFF, ramp(32'h1100_0000));
        for (int c = 0; c < 8; c++) begin
            tick();
            if (c == 7) req_valid = '0;
            at_neg();
            chk("rr_grant", L*DW'(grant_id), L*DW'(c % 2));
            chk("rr_write_en_nonzero", L*DW'(write_en != '0), L*DW'(1'b1));
        end
        chk("rr_stall_cnt", L*DW'(stall_cnt), '0);
        tick();

        // Hold behaviour
        do_reset();
        set_req(0, 1'b1, 5'h07, 16'hFFFF, ramp(32'h7000_0000));
        tick();
        set_req(0, 1'b1, 5'h08, 16'hFFFF, ramp(32'h8000_0000));
        wb_hold = 1'b1;
        for (int h = 0; h < 3; h++) begin
            at_neg();
            chk("hold_write_en", L*DW'(write_en), '0);
            chk("hold_ready", L*DW'(req_ready), '0);
            chk("hold_waddr", L*DW'(waddr), L*DW'(5'h07));
            tick();
        end
        wb_hold = 1'b0;
        at_neg();
        chk("hold_stall_cnt", L*DW'(stall_cnt), L*DW'(16'd3));
        chk("hold_release_we", L*DW'(write_en), L*DW'(16'hFFFF));
        chk("hold_release_ready", L*DW'(req_ready), L*DW'(2'b01));
        tick();
        req_valid = '0;
        chk("hold_bank_l0", L*DW'(dut_bank[7][0]), L*DW'(32'h7000_0000));
        chk("hold_bank_l15", L*DW'(dut_bank[7][15]), L*DW'(32'h7000_000F));
        at_neg();
        chk("hold_next_waddr", L*DW'(waddr), L*DW'(5'h08));
        tick();

        // Zero mask
        do_reset();
        set_req(0, 1'b1, 5'h02, 16'h0000, ramp(32'h2000_0000));
        at_neg();
        chk("zero_ready", L*DW'(req_ready), L*DW'(2'b01));
        tick();
        req_valid = '0;
        at_neg();
        chk("zero_write_en", L*DW'(write_en), '0);
        chk("zero_grant", L*DW'(grant_id), '0);
        tick();
        chk("zero_bank", L*DW'(dut_bank[2][0]), L*DW'(init_val(2, 0)));
        set_req(0, 1'b1, 5'h04, 16'hFFFF, ramp(32'h4000_0000));
        set_req(1, 1'b1, 5'h05, 16'hFFFF, ramp(32'h5000_0000));
        at_neg();
        chk("zero_ptr_advanced", L*DW'(req_ready), L*DW'(2'b10));
        tick();
        req_valid = '0;
        tick();
        tick();

        // Reset mid-write
        do_reset();
        set_req(0, 1'b1, 5'h03, 16'hFFFF, ramp(32'hA000_0000));
        tick();
        req_valid = '0;
        rst_n = 1'b0;
        #1;
        chk("midrst_write_en", L*DW'(write_en), '0);
        tick();
        rst_n = 1'b1;
        at_neg();
        chk("midrst_stall_cnt", L*DW'(stall_cnt), '0);
        chk("midrst_write_en_after", L*DW'(write_en), '0);
        tick();
        chk("midrst_bank_l0", L*DW'(dut_bank[3][0]), L*DW'(init_val(3, 0)));
        chk("midrst_bank_l15", L*DW'(dut_bank[3][15]), L*DW'(init_val(3, 15)));

        // Randomized run
        do_reset();
        for (int n = 0; n < 10000; n++) begin
            for (int i = 0; i < N; i++) begin
                if (req_valid[i] && s_ready[i]) req_valid[i] = 1'b0;
                if (!req_valid[i]) begin
                    if ($urandom_range(0, 3) != 0) begin
                        logic [L*DW-1:0] d;
                        for (int j = 0; j < L; j++) d[j*DW +: DW] = $urandom;
                        set_req(i, 1'b1, 5'($urandom_range(0, 31)),
                                ($urandom_range(0, 7) == 0) ? 16'h0000 : 16'($urandom), d);
                    end
                end else if ($urandom_range(0, 15) == 0) begin
                    req_valid[i] = 1'b0;
                end
            end
            wb_hold = ($urandom_range(0, 3) == 0);
            tick();
        end
        req_valid = '0;
        wb_hold   = 1'b0;
        tick();
        tick();
        tick();
        for (int r = 0; r < 32; r++) cmp_reg("rand_bank", r);
        chk("rand_queue_empty", L*DW'(exp_q.size()), '0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
